// File: rtl/quad_encoder_gen.sv
// Rotary encoder emulator: CPU command byte drives quadrature A/B detent steps
// and an optional push-switch press/release cycle.
module quad_encoder_gen #(
  parameter int unsigned CLK_DIV    = 1000,
  parameter int unsigned SW_HOLD    = 50000,
  parameter logic        SW_PRESSED = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gen_cmd_wr_stb,
  input  logic [7:0] gen_cmd_data,
  input  logic       gen_status_rd_stb,
  output logic [7:0] gen_status_reg,
  output logic       encoder_A,
  output logic       encoder_B,
  output logic       encoder_sw,
  output logic       busy
);

  localparam int unsigned DIV_MAX = (CLK_DIV > SW_HOLD) ? CLK_DIV : SW_HOLD;
  localparam int unsigned DIV_W   = ($clog2(DIV_MAX) > 0) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned STEP_W  = 6;
  localparam logic [DIV_W-1:0] ROT_RELOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HOLD_RELOAD = DIV_W'(SW_HOLD - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, PRESS, RELEASE} state_t;

  state_t            state_q, state_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [1:0]        idx_q, idx_n;
  logic [STEP_W-1:0] steps_q, steps_n;
  logic              dir_q, dir_n;
  logic              press_q, press_n;
  logic              overflow_q, overflow_n;
  logic [7:0]        status_q, status_n;
  logic              a_q, b_q, sw_q, sw_n, busy_q, busy_n;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      idx_q      <= 2'd0;
      steps_q    <= '0;
      dir_q      <= 1'b0;
      press_q    <= 1'b0;
      overflow_q <= 1'b0;
      status_q   <= 8'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      sw_q       <= ~SW_PRESSED;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      div_q      <= div_n;
      idx_q      <= idx_n;
      steps_q    <= steps_n;
      dir_q      <= dir_n;
      press_q    <= press_n;
      overflow_q <= overflow_n;
      status_q   <= status_n;
      a_q        <= idx_n[1] ^ idx_n[0];
      b_q        <= idx_n[1];
      sw_q       <= sw_n;
      busy_q     <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    div_n    = div_q;
    idx_n    = idx_q;
    steps_n  = steps_q;
    dir_n    = dir_q;
    press_n  = press_q;
    sw_n     = sw_q;
    busy_n   = busy_q;

    case (state_q)
      IDLE: begin
        if (gen_cmd_wr_stb) begin
          dir_n   = gen_cmd_data[7];
          press_n = gen_cmd_data[6];
          steps_n = gen_cmd_data[5:0];
          if (gen_cmd_data[5:0] != 6'd0) begin
            state_n = ROTATE;
            busy_n  = 1'b1;
            div_n   = ROT_RELOAD;
          end else if (gen_cmd_data[6]) begin
            state_n = PRESS;
            busy_n  = 1'b1;
            div_n   = HOLD_RELOAD;
            sw_n    = SW_PRESSED;
          end
        end
      end
      ROTATE: begin
        if (div_q != '0) begin
          div_n = DIV_W'(div_q - 1'b1);
        end else begin
          div_n = ROT_RELOAD;
          idx_n = dir_q ? 2'(idx_q + 2'd1) : 2'(idx_q - 2'd1);
          // Back at the detent: one full step done
          if (idx_n == 2'd0) begin
            steps_n = STEP_W'(steps_q - 1'b1);
            if (steps_q == 6'd1) begin
              if (press_q) begin
                state_n = PRESS;
                div_n   = HOLD_RELOAD;
                sw_n    = SW_PRESSED;
              end else begin
                state_n = IDLE;
                busy_n  = 1'b0;
              end
            end
          end
        end
      end
      PRESS: begin
        if (div_q != '0) begin
          div_n = DIV_W'(div_q - 1'b1);
        end else begin
          state_n = RELEASE;
          div_n   = HOLD_RELOAD;
          sw_n    = ~SW_PRESSED;
        end
      end
      RELEASE: begin
        if (div_q != '0) begin
          div_n = DIV_W'(div_q - 1'b1);
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Set wins over a coincident read-clear
    overflow_n = (overflow_q & ~gen_status_rd_stb) | (gen_cmd_wr_stb & busy_q);
    status_n   = gen_status_rd_stb ? {steps_q, overflow_q, busy_q} : status_q;
  end

  assign gen_status_reg = status_q;
  assign encoder_A      = a_q;
  assign encoder_B      = b_q;
  assign encoder_sw     = sw_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed self-checking bench for quad_encoder_gen (CLK_DIV=4, SW_HOLD=8).
module tb_quad_encoder_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       gen_cmd_wr_stb;
  logic [7:0] gen_cmd_data;
  logic       gen_status_rd_stb;
  logic [7:0] gen_status_reg;
  logic       encoder_A, encoder_B, encoder_sw, busy;

  int errors = 0;
  int checks = 0;

  int         chg_t [16];
  logic [1:0] chg_v [16];
  int         nchg, sw_fall, sw_rise, busy_len, idle_wait;

  quad_encoder_gen #(.CLK_DIV(4), .SW_HOLD(8), .SW_PRESSED(1'b0)) dut (
    .clk               (clk),
    .reset             (reset),
    .gen_cmd_wr_stb    (gen_cmd_wr_stb),
    .gen_cmd_data      (gen_cmd_data),
    .gen_status_rd_stb (gen_status_rd_stb),
    .gen_status_reg    (gen_status_reg),
    .encoder_A         (encoder_A),
    .encoder_B         (encoder_B),
    .encoder_sw        (encoder_sw),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Strobe sampled on the posedge between the two negedges; returns at t=0
  task automatic issue(input logic [7:0] c);
    @(negedge clk);
    gen_cmd_data   = c;
    gen_cmd_wr_stb = 1'b1;
    @(negedge clk);
    gen_cmd_wr_stb = 1'b0;
  endtask

  task automatic read_status();
    @(negedge clk);
    gen_status_rd_stb = 1'b1;
    @(negedge clk);
    gen_status_rd_stb = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = -1;
    for (int i = 0; i <= budget; i++) begin
      if (!busy) begin n = i; break; end
      @(negedge clk);
    end
  endtask

  // Issue a command and record every A/B and sw change until busy drops
  task automatic trace(input logic [7:0] c, input int budget);
    logic [1:0] pba;
    logic       psw;
    pba = {encoder_B, encoder_A};
    psw = encoder_sw;
    nchg = 0; sw_fall = -1; sw_rise = -1; busy_len = -1;
    issue(c);
    for (int t = 0; t <= budget; t++) begin
      if (t > 0) @(negedge clk);
      if ({encoder_B, encoder_A} != pba) begin
        if (nchg < 16) begin
          chg_t[nchg] = t;
          chg_v[nchg] = {encoder_B, encoder_A};
        end
        nchg++;
        pba = {encoder_B, encoder_A};
      end
      if (encoder_sw != psw) begin
        if (encoder_sw == 1'b0) sw_fall = t; else sw_rise = t;
        psw = encoder_sw;
      end
      if (!busy) begin busy_len = t; break; end
    end
  endtask

  initial begin
    int         cw_t [4];
    logic [1:0] cw_v [4];
    logic [1:0] ccw_v [4];
    cw_t  = '{4, 8, 12, 16};
    cw_v  = '{2'b01, 2'b11, 2'b10, 2'b00};
    ccw_v = '{2'b10, 2'b11, 2'b01, 2'b00};

    reset = 1'b1; gen_cmd_wr_stb = 1'b0; gen_cmd_data = 8'd0; gen_status_rd_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_A", encoder_A, 0);
    check("rst_B", encoder_B, 0);
    check("rst_sw", encoder_sw, 1);
    check("rst_busy", busy, 0);
    check("rst_status", gen_status_reg, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: cw one step
    trace(8'h81, 200);
    check("t1_busy_len", busy_len, 16);
    check("t1_nchg", nchg, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_chg%0d_t", i), chg_t[i], cw_t[i]);
      check($sformatf("t1_chg%0d_ba", i), chg_v[i], cw_v[i]);
    end
    check("t1_sw_fall", sw_fall, -1);

    // 2: ccw two steps
    trace(8'h02, 200);
    check("t2_busy_len", busy_len, 32);
    check("t2_nchg", nchg, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_chg%0d_t", i), chg_t[i], 4 * (i + 1));
      check($sformatf("t2_chg%0d_ba", i), chg_v[i], ccw_v[i % 4]);
    end
    check("t2_end_ba", {encoder_B, encoder_A}, 0);

    // 3: press only
    trace(8'h40, 200);
    check("t3_busy_len", busy_len, 16);
    check("t3_nchg", nchg, 0);
    check("t3_sw_fall", sw_fall, 0);
    check("t3_sw_rise", sw_rise, 8);

    // 4: cw one step then press
    trace(8'hC1, 200);
    check("t4_busy_len", busy_len, 32);
    check("t4_nchg", nchg, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_chg%0d_t", i), chg_t[i], cw_t[i]);
      check($sformatf("t4_chg%0d_ba", i), chg_v[i], cw_v[i]);
    end
    check("t4_sw_fall", sw_fall, 16);
    check("t4_sw_rise", sw_rise, 24);

    // 5: write while busy, status reads
    issue(8'h85);                 // t=0
    issue(8'h01);                 // sampled at edge 2, t=2
    repeat (17) @(negedge clk);   // t=19
    read_status();                // sampled at edge 21
    check("t5_status_rd1", gen_status_reg, 8'h13);
    read_status();                // sampled at edge 23
    check("t5_status_rd2", gen_status_reg, 8'h11);
    repeat (17) @(negedge clk);   // t=40
    check("t5_status_hold", gen_status_reg, 8'h11);
    wait_idle(200, idle_wait);
    check("t5_idle_wait", idle_wait, 40);
    read_status();
    check("t5_status_end", gen_status_reg, 8'h00);
    repeat (20) @(negedge clk);
    check("t5_no_restart", busy, 0);
    check("t5_ba_rest", {encoder_B, encoder_A}, 0);

    // 6: reset mid-command
    issue(8'h83);                 // t=0
    issue(8'h01);                 // overflow set at edge 2
    repeat (6) @(negedge clk);    // t=8
    check("t6_ba_pre", {encoder_B, encoder_A}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_ba", {encoder_B, encoder_A}, 0);
    check("t6_sw", encoder_sw, 1);
    check("t6_busy", busy, 0);
    check("t6_status", gen_status_reg, 0);
    read_status();
    check("t6_status_rd", gen_status_reg, 0);
    issue(8'h00);
    check("t6_noop_busy", busy, 0);
    repeat (6) @(negedge clk);
    check("t6_noop_busy2", busy, 0);
    check("t6_noop_ba", {encoder_B, encoder_A}, 0);
    check("t6_noop_sw", encoder_sw, 1);
    read_status();
    check("t6_noop_status", gen_status_reg, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
